pcs_rx_block_sync: RTL and testbench
====================================

Name: pcs_rx_block_sync

Overview:
- Receive-side neighbour of the PCS TX gearbox path.
- Consumes the 32-bit serial-word stream that the TX gearbox produces (transceiver or loopback) and rebuilds 66-bit blocks.
- Searches bit alignment by slipping, runs an IEEE 802.3 Clause 49 style block-lock state machine, and presents aligned sync header plus 64-bit payload to the downstream descrambler.
- Descrambling and 64b/66b decoding are out of scope.

Parameters:
- DATA_WIDTH, 32, input word width; only 32 is supported.
- SH_CNT_MAX, 64, number of blocks in a sync-header test window.
- SH_INVLD_MAX, 16, invalid headers per window that cause loss of lock.

Ports:
- i_clk  input  1  single clock, rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_rx_data  input  32  received word; bit 0 is the earliest received bit.
- i_rx_valid  input  1  i_rx_data is valid this cycle; no backpressure.
- o_sync_hdr  output  2  header of the emitted block; bit 0 is the first received bit.
- o_data  output  64  payload; o_data[31:0] is the first 32 payload bits received.
- o_valid  output  1  one-cycle pulse per emitted block; asserted only while locked.
- o_hdr_err  output  1  qualifies o_valid; emitted block header is 2'b00 or 2'b11.
- o_block_lock  output  1  block lock achieved.
- o_slip  output  1  one-cycle pulse when a bit slip is applied (debug and verification).

Behaviour:
- Reset (asynchronous assert, synchronous release): all outputs 0; buffer and bit count cleared; FSM in HUNT; all counters 0.
- Buffer: 98-bit register plus bit count (0..97).
  - On i_rx_valid, the 32 input bits are appended above the current count.
  - With no i_rx_valid, nothing changes.
- Extraction: when count after append is 66 or more, buffer bits [65:0] form the candidate block.
  - hdr = bits[1:0]; payload = bits[65:2].
  - Buffer shifts down by 66; count decreases by 66.
  - At most one extraction per cycle.
  - Steady state: 16 extractions per 33 valid words.
- Slip: when the FSM requests a slip on a block, that block is discarded and the buffer shifts by 67 instead of 66.
  - If the count is exactly 66, the slip is deferred: the next appended word drops its bit 0.
  - o_slip pulses in the cycle the slip is committed.
- Header validity: 2'b01 or 2'b10 is valid; 2'b00 or 2'b11 is invalid.
- FSM states:
  - HUNT: block_lock=0.
    - Valid header: sh_cnt++. When sh_cnt reaches SH_CNT_MAX, go to LOCKED and clear sh_cnt and invld_cnt.
    - Invalid header: slip, sh_cnt=0.
  - LOCKED: block_lock=1.
    - Every block: sh_cnt++. Invalid header: invld_cnt++.
    - invld_cnt reaching SH_INVLD_MAX: go to HUNT with block_lock=0, slip on that block, clear counters.
    - Otherwise, when sh_cnt reaches SH_CNT_MAX: clear sh_cnt and invld_cnt and stay in LOCKED.
    - The SH_INVLD_MAX check has priority when both limits are reached on the same block.
- Output latency:
  - o_sync_hdr, o_data, o_valid and o_hdr_err are registered and appear the cycle after the extraction cycle (1-cycle latency).
  - o_block_lock updates in the same cycle as the output of the block that caused the transition.
  - The 64th valid block in HUNT is itself emitted with o_valid=1.
  - The block causing loss of lock is not emitted.
- o_data and o_sync_hdr hold their last value when o_valid=0.
- Reset asserted mid-operation: everything clears immediately; after release, a full HUNT window is required before lock.

Test Plan:
- Aligned stream, hdr 2'b10, payload 0, continuous i_rx_valid -> o_block_lock rises with the 64th block; o_valid count equals 16 per 33 input words thereafter; o_hdr_err=0.
- Same stream delayed by 2 bits -> exactly 64 o_slip pulses, then lock after 64 further valid blocks; emitted o_data=64'h0, o_sync_hdr=2'b10.
- Locked, inject 15 bad headers (2'b11) in one 64-block window -> lock held, 15 o_hdr_err pulses. Repeat with 16 -> o_block_lock=0 on the 16th, o_slip pulse, no o_valid for that block.
- Gaps: i_rx_valid toggling 1/0 -> block contents identical to the continuous case; no spurious o_valid.
- Loopback from the TX PCS golden model (encode, scramble, gearbox) with random XGMII frames -> after lock, o_sync_hdr and o_data match the model's scrambled blocks in order.
- Reset pulse while locked mid-block -> all outputs 0 within the reset; relock takes 64 blocks after release.

Source files
------------

// File: rtl/pcs_rx_block_sync.sv
// Purpose: rebuild 66-bit blocks from the 32-bit serial-word stream, hunt bit alignment by slipping, hold block lock.
// Latency: one cycle from the extracting word to o_valid/o_sync_hdr/o_data/o_hdr_err; o_block_lock and o_slip move on that same edge.
// Backpressure: none; every i_rx_valid word is consumed, and a block leaves the cycle it completes.
//
// Ports:
//   i_clk, i_reset_n         clock, asynchronous active-low reset
//   i_rx_data, i_rx_valid    received word (bit 0 earliest) and its qualifier
//   o_sync_hdr, o_data       header (bit 0 first) and 64-bit payload of the emitted block; held while o_valid=0
//   o_valid, o_hdr_err       one-cycle block strobe while locked; o_hdr_err flags a 2'b00/2'b11 header
//   o_block_lock, o_slip     lock status; one-cycle pulse when a bit slip is requested
module pcs_rx_block_sync #(
  parameter int DATA_WIDTH   = 32,
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_valid,
  output logic [1:0]            o_sync_hdr,
  output logic [63:0]           o_data,
  output logic                  o_valid,
  output logic                  o_hdr_err,
  output logic                  o_block_lock,
  output logic                  o_slip
);

  localparam int BLK_W = 66;
  localparam int BUF_W = BLK_W + DATA_WIDTH;
  localparam int CNT_W = $clog2(BUF_W);
  localparam int SH_W  = $clog2(SH_CNT_MAX + 1);
  localparam int IV_W  = $clog2(SH_INVLD_MAX + 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              slip_pend_q, slip_pend_d;
  logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
  logic [IV_W-1:0]   invld_cnt_q, invld_cnt_d;
  logic [1:0]        sync_hdr_q, sync_hdr_d;
  logic [63:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              hdr_err_q, hdr_err_d;
  logic              slip_q, slip_d;

  logic [BUF_W-1:0]  in_ext;
  logic [BUF_W-1:0]  buf_app;
  logic [CNT_W-1:0]  cnt_app;
  logic              extract;
  logic [1:0]        hdr;
  logic [63:0]       payload;
  logic              hdr_ok;
  logic              slip_req;
  logic              emit;
  logic [SH_W-1:0]   sh_inc;
  logic [IV_W-1:0]   iv_inc;

  // Append the new word above the bits already held. A deferred slip eats
  // bit 0 of the next word, so that word contributes only 31 bits.
  always_comb begin
    in_ext  = '0;
    buf_app = buf_q;
    cnt_app = cnt_q;
    if (i_rx_valid) begin
      if (slip_pend_q) begin
        in_ext  = BUF_W'(i_rx_data >> 1);
        cnt_app = cnt_q + CNT_W'(DATA_WIDTH - 1);
      end else begin
        in_ext  = BUF_W'(i_rx_data);
        cnt_app = cnt_q + CNT_W'(DATA_WIDTH);
      end
      buf_app = buf_q | (in_ext << cnt_q);
    end
    extract = (cnt_app >= CNT_W'(BLK_W));
    hdr     = buf_app[1:0];
    payload = buf_app[65:2];
    hdr_ok  = hdr[0] ^ hdr[1];
  end

  // Block-lock state machine; only advances on an extracted candidate block.
  always_comb begin
    state_d     = state_q;
    sh_cnt_d    = sh_cnt_q;
    invld_cnt_d = invld_cnt_q;
    slip_req    = 1'b0;
    emit        = 1'b0;
    sh_inc      = sh_cnt_q + SH_W'(1);
    iv_inc      = invld_cnt_q + (hdr_ok ? IV_W'(0) : IV_W'(1));
    if (extract) begin
      case (state_q)
        HUNT: begin
          if (hdr_ok) begin
            if (sh_inc == SH_W'(SH_CNT_MAX)) begin
              // The block completing the window is already aligned: emit it.
              state_d     = LOCKED;
              sh_cnt_d    = '0;
              invld_cnt_d = '0;
              emit        = 1'b1;
            end else begin
              sh_cnt_d = sh_inc;
            end
          end else begin
            slip_req = 1'b1;
            sh_cnt_d = '0;
          end
        end
        LOCKED: begin
          // Loss-of-lock wins over the window wrap on the same block.
          if (iv_inc == IV_W'(SH_INVLD_MAX)) begin
            state_d     = HUNT;
            slip_req    = 1'b1;
            sh_cnt_d    = '0;
            invld_cnt_d = '0;
          end else begin
            emit = 1'b1;
            if (sh_inc == SH_W'(SH_CNT_MAX)) begin
              sh_cnt_d    = '0;
              invld_cnt_d = '0;
            end else begin
              sh_cnt_d    = sh_inc;
              invld_cnt_d = iv_inc;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Buffer consume: 66 bits per block, 67 on a slip. With exactly 66 bits
  // present there is no 67th bit yet, so the extra bit is taken from the next word.
  always_comb begin
    buf_d       = buf_app;
    cnt_d       = cnt_app;
    slip_pend_d = slip_pend_q & ~i_rx_valid;
    if (extract) begin
      if (slip_req && (cnt_app > CNT_W'(BLK_W))) begin
        buf_d = buf_app >> (BLK_W + 1);
        cnt_d = cnt_app - CNT_W'(BLK_W + 1);
      end else begin
        buf_d = buf_app >> BLK_W;
        cnt_d = cnt_app - CNT_W'(BLK_W);
        if (slip_req) begin
          slip_pend_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sync_hdr_d = emit ? hdr : sync_hdr_q;
    data_d     = emit ? payload : data_q;
    valid_d    = emit;
    hdr_err_d  = emit & ~hdr_ok;
    slip_d     = slip_req;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= HUNT;
      buf_q       <= '0;
      cnt_q       <= '0;
      slip_pend_q <= 1'b0;
      sh_cnt_q    <= '0;
      invld_cnt_q <= '0;
      sync_hdr_q  <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      hdr_err_q   <= 1'b0;
      slip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      slip_pend_q <= slip_pend_d;
      sh_cnt_q    <= sh_cnt_d;
      invld_cnt_q <= invld_cnt_d;
      sync_hdr_q  <= sync_hdr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      hdr_err_q   <= hdr_err_d;
      slip_q      <= slip_d;
    end
  end

  assign o_sync_hdr   = sync_hdr_q;
  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_hdr_err    = hdr_err_q;
  assign o_slip       = slip_q;
  assign o_block_lock = (state_q == LOCKED);

endmodule

// File: tb/tb_pcs_rx_block_sync.sv
// Purpose: directed + randomized bench for pcs_rx_block_sync against a bit-queue reference model.
// Latency: outputs compared 1 ns after each rising edge against the model's prediction for that edge.
// Backpressure: none; the bench paces i_rx_valid itself.
module tb_pcs_rx_block_sync;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [31:0] i_rx_data = '0;
  logic        i_rx_valid = 1'b0;
  logic [1:0]  o_sync_hdr;
  logic [63:0] o_data;
  logic        o_valid;
  logic        o_hdr_err;
  logic        o_block_lock;
  logic        o_slip;

  pcs_rx_block_sync dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_sync_hdr   (o_sync_hdr),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_hdr_err    (o_hdr_err),
    .o_block_lock (o_block_lock),
    .o_slip       (o_slip)
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: received bits kept as a plain queue, blocks popped 66 at a time.
  bit          mq[$];
  bit          m_pend;
  bit          m_lock;
  int          m_sh;
  int          m_inv;
  logic        e_valid, e_err, e_slip;
  logic [1:0]  e_hdr;
  logic [63:0] e_data;

  task automatic model_reset();
    mq.delete();
    m_pend = 0; m_lock = 0; m_sh = 0; m_inv = 0;
    e_valid = 0; e_err = 0; e_slip = 0; e_hdr = '0; e_data = '0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] w);
    logic [1:0]  h;
    logic [63:0] d;
    bit good, slip, emit, junk;
    e_valid = 0; e_err = 0; e_slip = 0;
    if (v) begin
      for (int i = 0; i < 32; i++) begin
        if (i == 0 && m_pend) continue;
        mq.push_back(w[i]);
      end
      m_pend = 0;
    end
    if (mq.size() >= 66) begin
      h = {mq[1], mq[0]};
      for (int j = 0; j < 64; j++) d[j] = mq[j+2];
      good = (h == 2'b01) || (h == 2'b10);
      slip = 0; emit = 0;
      if (!m_lock) begin
        if (good) begin
          m_sh++;
          if (m_sh == 64) begin m_lock = 1; m_sh = 0; m_inv = 0; emit = 1; end
        end else begin
          slip = 1; m_sh = 0;
        end
      end else begin
        m_sh++;
        if (!good) m_inv++;
        if (m_inv == 16) begin
          m_lock = 0; slip = 1; m_sh = 0; m_inv = 0;
        end else begin
          emit = 1;
          if (m_sh == 64) begin m_sh = 0; m_inv = 0; end
        end
      end
      if (emit) begin e_valid = 1; e_hdr = h; e_data = d; e_err = !good; end
      for (int j = 0; j < 66; j++) junk = mq.pop_front();
      if (slip) begin
        e_slip = 1;
        if (mq.size() > 0) junk = mq.pop_front();
        else m_pend = 1;
      end
    end
  endtask

  // Transmit-side stream: 66-bit blocks serialized LSB first.
  bit tq[$];
  int bad_left  = 0;
  bit zero_mode = 1;

  task automatic gen_block();
    logic [1:0]  h;
    logic [63:0] p;
    if (bad_left > 0) begin h = 2'b11; bad_left--; end
    else if (zero_mode) h = 2'b10;
    else h = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
    p = zero_mode ? 64'h0 : {$urandom, $urandom};
    tq.push_back(h[0]);
    tq.push_back(h[1]);
    for (int i = 0; i < 64; i++) tq.push_back(p[i]);
  endtask

  task automatic tx_restart(input int skip);
    bit junk;
    tq.delete();
    gen_block();
    for (int i = 0; i < skip; i++) junk = tq.pop_front();
  endtask

  task automatic next_word(output logic [31:0] w);
    while (tq.size() < 32) gen_block();
    for (int i = 0; i < 32; i++) w[i] = tq.pop_front();
  endtask

  int s_valid = 0, s_err = 0, s_slip = 0, s_drop = 0;
  bit prev_lock = 0;

  task automatic step(input bit v);
    logic [31:0] w;
    w = $urandom;
    if (v) next_word(w);
    i_rx_valid = v;
    i_rx_data  = w;
    @(posedge i_clk);
    model_step(v, w);
    #1;
    chk("o_valid",      64'(o_valid),      64'(e_valid));
    chk("o_hdr_err",    64'(o_hdr_err),    64'(e_err));
    chk("o_slip",       64'(o_slip),       64'(e_slip));
    chk("o_block_lock", 64'(o_block_lock), 64'(m_lock));
    chk("o_sync_hdr",   64'(o_sync_hdr),   64'(e_hdr));
    chk("o_data",       o_data,            e_data);
    if (!v) chk("valid_after_gap", 64'(o_valid), 64'(0));
    if (o_valid) s_valid++;
    if (o_valid && o_hdr_err) s_err++;
    if (o_slip) s_slip++;
    if (prev_lock && !o_block_lock) begin
      s_drop++;
      chk("drop_slip",    64'(o_slip),  64'(1));
      chk("drop_novalid", 64'(o_valid), 64'(0));
    end
    prev_lock = o_block_lock;
  endtask

  task automatic wait_lock(input int bound, input string tag, output int n);
    n = 0;
    while (!m_lock && n < bound) begin
      step(1);
      n++;
    end
    chk(tag, 64'(o_block_lock), 64'(1));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(o_valid),      64'(0));
    chk({tag, "_err"},   64'(o_hdr_err),    64'(0));
    chk({tag, "_slip"},  64'(o_slip),       64'(0));
    chk({tag, "_lock"},  64'(o_block_lock), 64'(0));
    chk({tag, "_hdr"},   64'(o_sync_hdr),   64'(0));
    chk({tag, "_data"},  o_data,            64'(0));
  endtask

  task automatic do_reset();
    i_reset_n  = 1'b0;
    i_rx_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    model_reset();
    prev_lock = 0;
  endtask

  initial begin
    int n;
    model_reset();
    #12;
    chk_zero("reset");
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // Aligned all-zero stream with header 2'b10: lock on word 132 (64 blocks).
    zero_mode = 1; bad_left = 0;
    tx_restart(0);
    s_slip = 0; s_err = 0;
    wait_lock(400, "lock_aligned", n);
    chk("lock_words_aligned", 64'(n), 64'(132));
    chk("no_slip_aligned", 64'(s_slip), 64'(0));
    s_valid = 0;
    repeat (33) step(1);
    chk("valid_per_33_words", 64'(s_valid), 64'(16));
    chk("hdr_err_aligned", 64'(s_err), 64'(0));

    // Stream starting 2 bits late: 64 slips before reaching the true boundary.
    do_reset();
    tx_restart(2);
    s_slip = 0;
    wait_lock(1000, "lock_skip2", n);
    chk("slips_skip2", 64'(s_slip), 64'(64));
    chk("data_skip2", o_data, 64'h0);
    chk("hdr_skip2", 64'(o_sync_hdr), 64'(2'b10));

    // 15 bad headers cannot break lock in any window split.
    bad_left = 15; s_err = 0; s_drop = 0;
    repeat (200) step(1);
    chk("bad15_err_pulses", 64'(s_err), 64'(15));
    chk("bad15_no_drop", 64'(s_drop), 64'(0));
    chk("bad15_locked", 64'(o_block_lock), 64'(1));

    // A run of 32 bad headers puts at least 16 into one window.
    bad_left = 32; s_drop = 0;
    repeat (150) step(1);
    chk("bad32_drop", 64'(s_drop), 64'(1));
    wait_lock(2000, "relock_after_bad", n);

    // Random payloads, valid toggling 1/0, then random gaps.
    zero_mode = 0;
    for (int i = 0; i < 300; i++) step(i % 2 == 0);
    for (int i = 0; i < 400; i++) step($urandom_range(0, 3) != 0);

    // Random bit phase from reset, random payloads.
    do_reset();
    tx_restart($urandom_range(0, 65));
    wait_lock(1500, "lock_random_phase", n);
    for (int i = 0; i < 300; i++) step($urandom_range(0, 2) != 0);

    // Asynchronous reset while locked, mid-cycle.
    chk("pre_reset_locked", 64'(o_block_lock), 64'(1));
    #2;
    i_reset_n = 1'b0;
    #1;
    chk_zero("async_reset");
    i_rx_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    model_reset();
    prev_lock = 0;
    wait_lock(1500, "relock_after_reset", n);
    chk("relock_min_words", 64'(n >= 132), 64'(1));
    repeat (50) step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
